// File: rtl/scs_pkg.sv
// Shared FSM encoding and derived-size helpers for the scs_engine checksum engine.
// The ST_CHECK state exists only when SCS_VERIFY_EN is defined.
package scs_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_WRITE = 3'd3,
`ifdef SCS_VERIFY_EN
        ST_CHECK = 3'd4,
`endif
        ST_DONE  = 3'd5
    } scs_state_e;

    // Number of RAM words holding one checksum.
    function automatic int scs_nw(input int sum_w, input int data_w);
        return sum_w / data_w;
    endfunction

    // Weight-index counter width; at least one bit even for a single weight step.
    function automatic int scs_idx_w(input int steps);
        return (steps > 1) ? $clog2(steps) : 1;
    endfunction

endpackage

// File: rtl/scs_weight_acc.sv
// Shift-weighted accumulator: each enabled word is added as data << idx, where idx cycles
// 0..WEIGHT_STEPS-1. clr restarts both the sum and the weight index.
module scs_weight_acc
    import scs_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int SUM_W        = 16,
    parameter int WEIGHT_STEPS = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] data,
    output logic [SUM_W-1:0]  sum
);
    localparam int IDX_W = scs_idx_w(WEIGHT_STEPS);

    logic [IDX_W-1:0] widx_q, widx_d;
    logic [SUM_W-1:0] sum_q, sum_d;

    always_comb begin
        widx_d = widx_q;
        sum_d  = sum_q;
        if (clr) begin
            widx_d = '0;
            sum_d  = '0;
        end else if (en) begin
            sum_d  = sum_q + (SUM_W'(data) << widx_q);
            widx_d = (widx_q == IDX_W'(WEIGHT_STEPS - 1)) ? '0 : widx_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            widx_q <= '0;
            sum_q  <= '0;
        end else begin
            widx_q <= widx_d;
            sum_q  <= sum_d;
        end
    end

    assign sum = sum_q;

endmodule

// File: rtl/scs_engine.sv
// Weighted-checksum engine: streams a RAM window through scs_weight_acc and writes the sum back
// little-endian. Define SCS_VERIFY_EN to add verify mode (compare against the stored sum instead).
module scs_engine
    import scs_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int ADDR_W       = 10,
    parameter int SUM_W        = 16,
    parameter int WEIGHT_STEPS = 4,
    parameter int RD_LAT       = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] length,
    input  logic [ADDR_W-1:0] result_addr,
    input  logic              verify_mode,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic [SUM_W-1:0]  checksum,
    output logic              mismatch
);
    localparam int NW = scs_nw(SUM_W, DATA_W);

    scs_state_e        state_q, state_d, drain_exit;
    logic [ADDR_W-1:0] cnt_q, cnt_d, addr_q, addr_d, len_q, len_d, res_q, res_d;
    logic [RD_LAT-1:0] vld_q, vld_d;
    logic [SUM_W-1:0]  csum_q, csum_d, sum;
    logic              accept, vld_out, acc_en, finishing;

    assign accept    = (state_q == ST_IDLE) && start;
    assign vld_out   = vld_q[RD_LAT-1];
    assign finishing = (state_d == ST_DONE) && (state_q != ST_DONE);
    // Only window reads are in flight during READ/DRAIN; DRAIN lets the last one land.
    assign acc_en    = vld_out && ((state_q == ST_READ) || (state_q == ST_DRAIN));

    scs_weight_acc #(
        .DATA_W      (DATA_W),
        .SUM_W       (SUM_W),
        .WEIGHT_STEPS(WEIGHT_STEPS)
    ) u_acc (
        .clock  (clock),
        .reset_n(reset_n),
        .clr    (accept),
        .en     (acc_en),
        .data   (mem_rdata),
        .sum    (sum)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = (length == '0) ? ST_DRAIN : ST_READ;
            ST_READ:  if (cnt_q == len_q - 1'b1) state_d = ST_DRAIN;
            ST_DRAIN: if (cnt_q == ADDR_W'(RD_LAT - 1)) state_d = drain_exit;
            ST_WRITE: if (cnt_q == ADDR_W'(NW - 1)) state_d = ST_DONE;
`ifdef SCS_VERIFY_EN
            ST_CHECK: if (cnt_q == ADDR_W'(NW + RD_LAT - 1)) state_d = ST_DONE;
`endif
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_rd_en = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        busy      = (state_q != ST_IDLE);
        done      = (state_q == ST_DONE);
        case (state_q)
            ST_READ:  mem_rd_en = 1'b1;
            ST_WRITE: begin
                mem_we    = 1'b1;
                mem_wdata = DATA_W'(sum >> (DATA_W * int'(cnt_q)));
            end
`ifdef SCS_VERIFY_EN
            ST_CHECK: mem_rd_en = (cnt_q < ADDR_W'(NW));
`endif
            default: ;
        endcase
    end

    always_comb begin
        len_d  = len_q;
        res_d  = res_q;
        addr_d = addr_q;
        cnt_d  = ((state_q == ST_IDLE) || (state_d != state_q)) ? '0 : cnt_q + 1'b1;
        vld_d  = RD_LAT'({vld_q, mem_rd_en});
        csum_d = finishing ? sum : csum_q;
        case (state_q)
            ST_IDLE: if (start) begin
                len_d  = length;
                res_d  = result_addr;
                addr_d = (length == '0) ? result_addr : base_addr;
            end
            // Preload the result address after the last read so DRAIN needs no address update.
            ST_READ:  addr_d = (state_d == ST_DRAIN) ? res_q : addr_q + 1'b1;
            ST_WRITE: if (cnt_q < ADDR_W'(NW - 1)) addr_d = addr_q + 1'b1;
`ifdef SCS_VERIFY_EN
            ST_CHECK: if (cnt_q < ADDR_W'(NW - 1)) addr_d = addr_q + 1'b1;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            addr_q <= '0;
            len_q  <= '0;
            res_q  <= '0;
            vld_q  <= '0;
            csum_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            addr_q <= addr_d;
            len_q  <= len_d;
            res_q  <= res_d;
            vld_q  <= vld_d;
            csum_q <= csum_d;
        end
    end

    assign mem_addr = addr_q;
    assign checksum = csum_q;

`ifdef SCS_VERIFY_EN
    logic              verify_q, verify_d, miss_q, miss_d, mism_q, mism_d;
    logic [ADDR_W-1:0] cidx_q, cidx_d;

    assign drain_exit = verify_q ? ST_CHECK : ST_WRITE;

    // Stored words return in address order, so a running index selects the sum word to compare.
    always_comb begin
        verify_d = accept ? verify_mode : verify_q;
        miss_d   = miss_q;
        cidx_d   = cidx_q;
        mism_d   = mism_q;
        if (accept) begin
            miss_d = 1'b0;
            cidx_d = '0;
        end else if ((state_q == ST_CHECK) && vld_out) begin
            cidx_d = cidx_q + 1'b1;
            if (mem_rdata != DATA_W'(sum >> (DATA_W * int'(cidx_q)))) miss_d = 1'b1;
        end
        if (finishing) mism_d = (state_q == ST_CHECK) ? miss_d : 1'b0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            verify_q <= 1'b0;
            miss_q   <= 1'b0;
            mism_q   <= 1'b0;
            cidx_q   <= '0;
        end else begin
            verify_q <= verify_d;
            miss_q   <= miss_d;
            mism_q   <= mism_d;
            cidx_q   <= cidx_d;
        end
    end

    assign mismatch = mism_q;
`else
    assign drain_exit = ST_WRITE;
    // verify_mode has no function in this build.
    assign mismatch   = 1'b0 & verify_mode;
`endif

endmodule
